dma_burst_gen: RTL and testbench

- Splits one programmed DMA transfer into AXI-legal burst commands. The transfer is given as start, source_addr, dest_addr and length (in 32-bit words).
- Sits between the DMA register slave and the DMA AXI master. It consumes the slave's start/address/length outputs and feeds the master one command per burst.
- Limits each burst to MAX_BEATS and prevents it from crossing a BOUNDARY-byte page on either source or destination.
- Tracks outstanding bursts and pulses done when the whole transfer has completed.

---
 rtl/dma_burst_gen_pkg.sv | 36 +++
 rtl/dma_burst_gen_if.sv | 34 +++
 rtl/dma_burst_gen_beat_calc.sv | 39 +++
 rtl/dma_burst_gen.sv | 127 ++++++++++++
 tb/tb_dma_burst_gen.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dma_burst_gen_pkg.sv
// Shared types and defaults for the DMA burst generator slice.
// State encodings stay as plain constants so legacy code comparing raw values keeps working.
package dma_pkg;

    localparam int unsigned WORD_BYTES          = 4;
    localparam int unsigned DEF_ADDR_W          = 32;
    localparam int unsigned DEF_LEN_W           = 32;
    localparam int unsigned DEF_MAX_BEATS       = 16;
    localparam int unsigned DEF_BOUNDARY        = 4096;
    localparam int unsigned DEF_MAX_OUTSTANDING = 4;

    localparam int unsigned BOUNDARY_LOG2 = $clog2(DEF_BOUNDARY);
    localparam int unsigned BEATS_W       = $clog2(DEF_MAX_BEATS) + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CALC  = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = S_IDLE,
        CALC  = S_CALC,
        ISSUE = S_ISSUE,
        DRAIN = S_DRAIN,
        DONE  = S_DONE
    } state_e;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] src;
        logic [DEF_ADDR_W-1:0] dst;
        logic [3:0]            len;
        logic                  last;
    } cmd_t;

endpackage

// File: rtl/dma_burst_gen_if.sv
// Transfer request, burst command and completion signals between the DMA
// register slave, the burst generator (slave modport) and the AXI master side.
interface dma_burst_gen_if #(
    parameter int unsigned ADDR_W = dma_pkg::DEF_ADDR_W,
    parameter int unsigned LEN_W  = dma_pkg::DEF_LEN_W
);

    logic              start;
    logic [ADDR_W-1:0] source_addr;
    logic [ADDR_W-1:0] dest_addr;
    logic [LEN_W-1:0]  length;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_src_addr;
    logic [ADDR_W-1:0] cmd_dst_addr;
    logic [3:0]        cmd_len;
    logic              cmd_last;

    logic              burst_done;
    logic              busy;
    logic              done;

    modport slave (
        input  start, source_addr, dest_addr, length, cmd_ready, burst_done,
        output cmd_valid, cmd_src_addr, cmd_dst_addr, cmd_len, cmd_last, busy, done
    );

    modport master (
        output start, source_addr, dest_addr, length, cmd_ready, burst_done,
        input  cmd_valid, cmd_src_addr, cmd_dst_addr, cmd_len, cmd_last, busy, done
    );

endinterface

// File: rtl/dma_burst_gen_beat_calc.sv
// Combinational burst sizer: min(remaining, MAX_BEATS, words left in the
// source page, words left in the destination page).
module dma_beat_calc
    import dma_pkg::*;
#(
    parameter int unsigned LEN_W     = DEF_LEN_W,
    parameter int unsigned MAX_BEATS = DEF_MAX_BEATS,
    parameter int unsigned BOUNDARY  = DEF_BOUNDARY,
    parameter int unsigned PG_W      = $clog2(BOUNDARY),
    parameter int unsigned BEATS_W   = $clog2(MAX_BEATS) + 1
) (
    input  logic [PG_W-1:0]    i_src_off,
    input  logic [PG_W-1:0]    i_dst_off,
    input  logic [LEN_W-1:0]   i_remaining,
    output logic [BEATS_W-1:0] o_beats
);

    localparam int unsigned ROOM_W = PG_W + 1;
    localparam int unsigned WSH    = $clog2(WORD_BYTES);

    logic [ROOM_W-1:0] w_src_room;
    logic [ROOM_W-1:0] w_dst_room;
    logic [ROOM_W-1:0] w_room;
    logic [ROOM_W-1:0] w_cap;

    always_comb begin
        // Offsets are word aligned, so the byte distance divides exactly.
        w_src_room = (ROOM_W'(BOUNDARY) - {1'b0, i_src_off}) >> WSH;
        w_dst_room = (ROOM_W'(BOUNDARY) - {1'b0, i_dst_off}) >> WSH;
        w_room     = (w_src_room < w_dst_room) ? w_src_room : w_dst_room;
        w_cap      = (w_room < ROOM_W'(MAX_BEATS)) ? w_room : ROOM_W'(MAX_BEATS);
        if (i_remaining < LEN_W'(w_cap)) begin
            o_beats = BEATS_W'(i_remaining);
        end else begin
            o_beats = BEATS_W'(w_cap);
        end
    end

endmodule

// File: rtl/dma_burst_gen.sv
// Splits one DMA transfer into page-safe, length-capped burst commands and
// tracks outstanding bursts until the whole transfer has completed.
module dma_burst_gen
    import dma_pkg::*;
#(
    parameter int unsigned ADDR_W          = DEF_ADDR_W,
    parameter int unsigned LEN_W           = DEF_LEN_W,
    parameter int unsigned MAX_BEATS       = DEF_MAX_BEATS,
    parameter int unsigned BOUNDARY        = DEF_BOUNDARY,
    parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
    input logic             clk,
    input logic             rst,
    dma_burst_gen_if.slave  bus
);

    localparam int unsigned PG_W  = $clog2(BOUNDARY);
    localparam int unsigned BW    = $clog2(MAX_BEATS) + 1;
    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [2:0]       r_state;
    cmd_t             r_cmd;
    logic [LEN_W-1:0] r_rem;
    logic [BW-1:0]    r_beats;
    logic [OUT_W-1:0] r_out;
    logic             r_cmd_valid;

    logic [BW-1:0]     w_beats;
    logic              w_hs;
    logic [OUT_W-1:0]  w_out_nxt;
    logic [ADDR_W-1:0] w_step;
    logic [ADDR_W-1:0] w_src_nxt;
    logic [ADDR_W-1:0] w_dst_nxt;

    dma_beat_calc #(
        .LEN_W     (LEN_W),
        .MAX_BEATS (MAX_BEATS),
        .BOUNDARY  (BOUNDARY),
        .PG_W      (PG_W),
        .BEATS_W   (BW)
    ) u_beat_calc (
        .i_src_off   (r_cmd.src[PG_W-1:0]),
        .i_dst_off   (r_cmd.dst[PG_W-1:0]),
        .i_remaining (r_rem),
        .o_beats     (w_beats)
    );

    assign w_hs      = r_cmd_valid & bus.cmd_ready;
    assign w_step    = ADDR_W'(r_beats) * ADDR_W'(WORD_BYTES);
    assign w_src_nxt = ADDR_W'(r_cmd.src) + w_step;
    assign w_dst_nxt = ADDR_W'(r_cmd.dst) + w_step;

    // A handshake and a completion in the same cycle cancel out.
    always_comb begin
        w_out_nxt = r_out;
        if (w_hs && !bus.burst_done) begin
            w_out_nxt = r_out + 1'b1;
        end else if (!w_hs && bus.burst_done && (r_out != '0)) begin
            w_out_nxt = r_out - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cmd       <= '0;
            r_rem       <= '0;
            r_beats     <= '0;
            r_out       <= '0;
            r_cmd_valid <= 1'b0;
        end else begin
            r_out <= w_out_nxt;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_cmd.src <= DEF_ADDR_W'(bus.source_addr & ~ADDR_W'(3));
                        r_cmd.dst <= DEF_ADDR_W'(bus.dest_addr & ~ADDR_W'(3));
                        r_rem     <= bus.length;
                        r_state   <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (r_rem == '0) begin
                        r_state <= S_DRAIN;
                    end else begin
                        r_beats    <= w_beats;
                        r_cmd.len  <= 4'(w_beats - 1'b1);
                        r_cmd.last <= (r_rem == LEN_W'(w_beats));
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (w_hs) begin
                        r_cmd_valid <= 1'b0;
                        r_cmd.src   <= DEF_ADDR_W'(w_src_nxt);
                        r_cmd.dst   <= DEF_ADDR_W'(w_dst_nxt);
                        r_rem       <= r_rem - LEN_W'(r_beats);
                        r_state     <= r_cmd.last ? S_DRAIN : S_CALC;
                    end else if (w_out_nxt < OUT_W'(MAX_OUTSTANDING)) begin
                        // Outstanding never rises without a handshake, so valid stays up once set.
                        r_cmd_valid <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (w_out_nxt == '0) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_valid    = r_cmd_valid;
    assign bus.cmd_src_addr = ADDR_W'(r_cmd.src);
    assign bus.cmd_dst_addr = ADDR_W'(r_cmd.dst);
    assign bus.cmd_len      = r_cmd.len;
    assign bus.cmd_last     = r_cmd.last;
    assign bus.busy         = (r_state != S_IDLE);
    assign bus.done         = (r_state == S_DONE);

endmodule

// File: tb/tb_dma_burst_gen.sv
// Directed bench for dma_burst_gen: table of transfers with hand-computed
// burst lists, plus sequences for zero length, outstanding limit and reset.
module tb_dma_burst_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    dma_burst_gen_if #(.ADDR_W(32), .LEN_W(32)) bus ();

    dma_burst_gen #(
        .ADDR_W          (32),
        .LEN_W           (32),
        .MAX_BEATS       (16),
        .BOUNDARY        (4096),
        .MAX_OUTSTANDING (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [31:0]       src;
        logic [31:0]       dst;
        logic [31:0]       len;
        logic [3:0]        ncmd;
        logic [2:0][31:0]  esrc;
        logic [2:0][31:0]  edst;
        logic [2:0][3:0]   elen;
    } vec_t;

    localparam int NV = 5;
    vec_t vec [NV];

    function automatic vec_t mk(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l,
                                input logic [3:0] n,
                                input logic [31:0] s0, input logic [31:0] s1, input logic [31:0] s2,
                                input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                                input logic [3:0] l0, input logic [3:0] l1, input logic [3:0] l2);
        vec_t v;
        v.src = s; v.dst = d; v.len = l; v.ncmd = n;
        v.esrc[0] = s0; v.esrc[1] = s1; v.esrc[2] = s2;
        v.edst[0] = d0; v.edst[1] = d1; v.edst[2] = d2;
        v.elen[0] = l0; v.elen[1] = l1; v.elen[2] = l2;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_xfer(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l);
        bus.source_addr = s;
        bus.dest_addr   = d;
        bus.length      = l;
        bus.start       = 1'b1;
        tick();
        bus.start       = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int        due[$];
        int        ncmd;
        int        ndone;
        int        hs;
        bit        seen;
        logic [31:0] s_hold;

        vec[0] = mk(32'h1000, 32'h2000, 40, 3, 32'h1000, 32'h1040, 32'h1080,
                    32'h2000, 32'h2040, 32'h2080, 4'd15, 4'd15, 4'd7);
        vec[1] = mk(32'h1FF0, 32'h3000, 10, 2, 32'h1FF0, 32'h2000, 32'h0,
                    32'h3000, 32'h3010, 32'h0, 4'd3, 4'd5, 4'd0);
        vec[2] = mk(32'h0, 32'h4FC0, 20, 2, 32'h0, 32'h40, 32'h0,
                    32'h4FC0, 32'h5000, 32'h0, 4'd15, 4'd3, 4'd0);
        vec[3] = mk(32'h0FFC, 32'h7FF8, 5, 3, 32'h0FFC, 32'h1000, 32'h1004,
                    32'h7FF8, 32'h7FFC, 32'h8000, 4'd0, 4'd0, 4'd2);
        vec[4] = mk(32'h1003, 32'h2002, 3, 1, 32'h1000, 32'h0, 32'h0,
                    32'h2000, 32'h0, 32'h0, 4'd2, 4'd0, 4'd0);

        bus.start = 1'b0; bus.source_addr = '0; bus.dest_addr = '0; bus.length = '0;
        bus.cmd_ready = 1'b0; bus.burst_done = 1'b0;
        tick(); tick();
        check("reset cmd_valid", 32'(bus.cmd_valid), 0);
        check("reset busy", 32'(bus.busy), 0);
        check("reset done", 32'(bus.done), 0);
        check("reset cmd_len", 32'(bus.cmd_len), 0);
        check("reset cmd_src", bus.cmd_src_addr, 0);
        check("reset cmd_last", 32'(bus.cmd_last), 0);
        rst = 1'b0;
        tick();

        // Table-driven transfers with an auto responder completing each burst 3 cycles later.
        bus.cmd_ready = 1'b1;
        for (int v = 0; v < NV; v++) begin
            start_xfer(vec[v].src, vec[v].dst, vec[v].len);
            due.delete();
            ncmd = 0;
            ndone = 0;
            for (int cyc = 0; cyc < 200 && ndone == 0; cyc++) begin
                if (bus.cmd_valid && bus.cmd_ready) begin
                    if (ncmd < 3) begin
                        check($sformatf("v%0d c%0d src", v, ncmd), bus.cmd_src_addr, vec[v].esrc[ncmd]);
                        check($sformatf("v%0d c%0d dst", v, ncmd), bus.cmd_dst_addr, vec[v].edst[ncmd]);
                        check($sformatf("v%0d c%0d len", v, ncmd), 32'(bus.cmd_len), 32'(vec[v].elen[ncmd]));
                        check($sformatf("v%0d c%0d last", v, ncmd), 32'(bus.cmd_last),
                              (ncmd == int'(vec[v].ncmd) - 1) ? 1 : 0);
                    end
                    ncmd++;
                    due.push_back(cyc + 3);
                end
                if (due.size() > 0 && due[0] == cyc) begin
                    bus.burst_done = 1'b1;
                    void'(due.pop_front());
                end else begin
                    bus.burst_done = 1'b0;
                end
                if (bus.done) ndone++;
                if (ndone == 0) tick();
            end
            bus.burst_done = 1'b0;
            check($sformatf("v%0d done seen", v), 32'(ndone), 1);
            check($sformatf("v%0d cmd count", v), 32'(ncmd), 32'(vec[v].ncmd));
            tick();
            check($sformatf("v%0d done pulse width", v), 32'(bus.done), 0);
            check($sformatf("v%0d busy after", v), 32'(bus.busy), 0);
        end

        // Zero length: no command, done two cycles after the start edge, busy for three cycles.
        start_xfer(32'h10, 32'h20, 0);
        check("len0 busy c0", 32'(bus.busy), 1);
        check("len0 done c0", 32'(bus.done), 0);
        check("len0 valid c0", 32'(bus.cmd_valid), 0);
        tick();
        check("len0 busy c1", 32'(bus.busy), 1);
        check("len0 done c1", 32'(bus.done), 0);
        check("len0 valid c1", 32'(bus.cmd_valid), 0);
        tick();
        check("len0 busy c2", 32'(bus.busy), 1);
        check("len0 done c2", 32'(bus.done), 1);
        check("len0 valid c2", 32'(bus.cmd_valid), 0);
        tick();
        check("len0 busy c3", 32'(bus.busy), 0);
        check("len0 done c3", 32'(bus.done), 0);

        // Stray completions while idle must not underflow the outstanding count.
        bus.burst_done = 1'b1;
        tick(); tick();
        bus.burst_done = 1'b0;

        // Outstanding limit with no completions; a start while busy is ignored.
        start_xfer(32'h8000, 32'h9000, 100);
        hs = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (bus.cmd_valid && bus.cmd_ready) hs++;
            if (cyc == 10) begin
                bus.source_addr = 32'h0; bus.dest_addr = 32'h0; bus.length = 3;
                bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            tick();
        end
        bus.start = 1'b0;
        check("limit handshakes", 32'(hs), 4);
        check("limit valid low", 32'(bus.cmd_valid), 0);
        check("limit busy", 32'(bus.busy), 1);

        bus.burst_done = 1'b1;
        tick();
        bus.burst_done = 1'b0;
        hs = 0;
        s_hold = '0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (bus.cmd_valid && bus.cmd_ready) begin
                hs++;
                s_hold = bus.cmd_src_addr;
            end
            tick();
        end
        check("one more handshake", 32'(hs), 1);
        check("fifth cmd src", s_hold, 32'h8100);

        // Hold off the master, free a slot, and watch the pending command stay stable.
        bus.cmd_ready = 1'b0;
        bus.burst_done = 1'b1;
        tick();
        bus.burst_done = 1'b0;
        seen = 1'b0;
        for (int cyc = 0; cyc < 20 && !seen; cyc++) begin
            if (bus.cmd_valid) seen = 1'b1;
            else tick();
        end
        check("sixth valid seen", 32'(seen), 1);
        check("sixth src", bus.cmd_src_addr, 32'h8140);
        check("sixth dst", bus.cmd_dst_addr, 32'h9140);
        check("sixth len", 32'(bus.cmd_len), 15);
        check("sixth last", 32'(bus.cmd_last), 0);
        tick(); tick(); tick();
        check("stall valid held", 32'(bus.cmd_valid), 1);
        check("stall src held", bus.cmd_src_addr, 32'h8140);

        // Asynchronous reset mid-command.
        rst = 1'b1;
        #1;
        check("rst valid", 32'(bus.cmd_valid), 0);
        check("rst busy", 32'(bus.busy), 0);
        check("rst src", bus.cmd_src_addr, 0);
        check("rst len", 32'(bus.cmd_len), 0);
        check("rst done", 32'(bus.done), 0);
        tick(); tick();
        rst = 1'b0;
        tick();

        bus.cmd_ready = 1'b1;
        start_xfer(32'h100, 32'h200, 1);
        check("post rst valid c0", 32'(bus.cmd_valid), 0);
        tick();
        check("post rst valid c1", 32'(bus.cmd_valid), 0);
        tick();
        check("post rst valid c2", 32'(bus.cmd_valid), 1);
        check("post rst src", bus.cmd_src_addr, 32'h100);
        check("post rst dst", bus.cmd_dst_addr, 32'h200);
        check("post rst len", 32'(bus.cmd_len), 0);
        check("post rst last", 32'(bus.cmd_last), 1);
        tick();
        check("post rst valid drop", 32'(bus.cmd_valid), 0);
        check("post rst done early", 32'(bus.done), 0);
        bus.burst_done = 1'b1;
        tick();
        bus.burst_done = 1'b0;
        check("post rst done", 32'(bus.done), 1);
        tick();
        check("post rst idle", 32'(bus.busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
